// File: rtl/qsys_pipeline_rx_fifo.sv
// qsys_pipeline_rx_fifo
//
// Receive-side buffer placed after a chain of qsys pipeline registers on a
// latency-insensitive link. Upstream keeps sending for a few cycles after
// o_ready drops, so o_ready is withdrawn while SLACK entries are still free.
// The downstream side is a first-word fall-through valid/ready interface.
//
// Ports:
//   clock      - single clock, all state on posedge
//   reset      - asynchronous, active-high reset
//   i_data     - payload from the upstream register chain
//   i_valid    - payload qualifier (accepted regardless of o_ready)
//   o_ready    - registered credit back to upstream
//   o_data     - head-of-FIFO payload
//   o_valid    - head entry present
//   i_ready    - downstream accepts o_data this cycle
//   o_count    - current occupancy
//   o_overflow - sticky: a word arrived while full and was dropped
module qsys_pipeline_rx_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int SLACK      = 5
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        i_data,
    input  logic                         i_valid,
    output logic                         o_ready,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH = CW'(DEPTH - SLACK);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;
    logic                  push;
    logic                  pop;

    assign o_valid = (count != '0);
    assign pop     = o_valid && i_ready;
    // At full a push is still possible when the head leaves in the same cycle.
    assign push    = i_valid && ((count < FULL) || pop);
    assign o_data  = mem[rd_ptr];
    assign o_count = count;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_ready    <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count   <= count_next;
            // Based on next occupancy so the credit reflects this cycle's traffic.
            o_ready <= (count_next < THRESH);
            // A valid word that could not be pushed is exactly the overflow case.
            if (i_valid && !push) o_overflow <= 1'b1;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= i_data;
    end

endmodule

// File: tb/tb_qsys_pipeline_rx_fifo.sv
module tb_qsys_pipeline_rx_fifo;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] i_data;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] o_data;
    logic        o_valid;
    logic        i_ready;
    logic [4:0]  o_count;
    logic        o_overflow;

    qsys_pipeline_rx_fifo #(.DATA_WIDTH(32), .DEPTH(16), .SLACK(5)) dut (
        .clock(clock), .reset(reset), .i_data(i_data), .i_valid(i_valid),
        .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_count(o_count), .o_overflow(o_overflow)
    );

    always #5 clock = ~clock;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [31:0] q[$];
    logic        m_ready = 1'b0;
    logic        m_ovf   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model before
    // the edge, then advance the model to the post-edge state.
    task automatic cyc(input logic v, input logic [31:0] d, input logic r);
        logic m_pop, m_push;
        i_valid = v; i_data = d; i_ready = r;
        @(negedge clock);
        chk("o_valid", o_valid, q.size() != 0);
        chk("o_count", o_count, q.size());
        chk("o_ready", o_ready, m_ready);
        chk("o_overflow", o_overflow, m_ovf);
        m_pop  = (q.size() != 0) && r;
        m_push = v && ((q.size() < 16) || m_pop);
        if (m_pop) begin
            chk("o_data", o_data, q[0]);
            void'(q.pop_front());
        end
        if (m_push) q.push_back(d);
        if (v && !m_push) m_ovf = 1'b1;
        m_ready = (q.size() < 11);
        @(posedge clock); #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) cyc(1'b0, '0, 1'b1);
        chk("drain_empty", o_valid, 1'b0);
    endtask

    logic        vp_v [2];
    logic [31:0] vp_d [2];
    logic        rp   [2];

    initial begin
        reset = 1'b1; i_valid = 1'b0; i_data = '0; i_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_o_valid", o_valid, 1'b0);
        chk("rst_o_count", o_count, 5'd0);
        chk("rst_o_ready", o_ready, 1'b0);
        chk("rst_o_overflow", o_overflow, 1'b0);
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;
        chk("rel_o_ready", o_ready, 1'b1);
        m_ready = 1'b1;

        // Passthrough 0x1..0x40
        for (int k = 1; k <= 64; k++) begin
            cyc(1'b1, 32'(k), 1'b1);
            chk("pass_count_le1", o_count <= 5'd1, 1'b1);
        end
        drain();

        // Backpressure with 2-stage delay each way
        begin
            int unsigned sent = 0;
            logic [4:0] maxc = '0;
            vp_v[0] = 0; vp_v[1] = 0; vp_d[0] = '0; vp_d[1] = '0;
            rp[0] = o_ready; rp[1] = o_ready;
            for (int c = 0; c < 40; c++) begin
                logic sv, dv;
                logic [31:0] dd;
                sv = rp[1] && (sent < 30);
                dv = vp_v[1]; dd = vp_d[1];
                vp_v[1] = vp_v[0]; vp_d[1] = vp_d[0];
                vp_v[0] = sv; vp_d[0] = 32'h100 + sent;
                if (sv) sent++;
                rp[1] = rp[0]; rp[0] = o_ready;
                cyc(dv, dd, 1'b0);
                if (o_count > maxc) maxc = o_count;
            end
            chk("bp_max_le16", maxc <= 5'd16, 1'b1);
            chk("bp_reached11", maxc >= 5'd11, 1'b1);
            chk("bp_ready_low", o_ready, 1'b0);
            chk("bp_overflow", o_overflow, 1'b0);
        end
        drain();

        // Fill to full, then push+pop at full
        for (int k = 0; k < 16; k++) cyc(1'b1, 32'h200 + k, 1'b0);
        chk("full_count", o_count, 5'd16);
        for (int k = 0; k < 10; k++) cyc(1'b1, 32'h300 + k, 1'b1);
        chk("full_pp_count", o_count, 5'd16);
        chk("full_pp_ovf", o_overflow, 1'b0);

        // Overflow: 0xDEAD dropped, flag sticky
        cyc(1'b1, 32'hDEAD, 1'b0);
        chk("ovf_set", o_overflow, 1'b1);
        chk("ovf_count", o_count, 5'd16);
        drain();
        chk("ovf_sticky", o_overflow, 1'b1);

        // Mid-stream asynchronous reset with 7 entries
        for (int k = 0; k < 7; k++) cyc(1'b1, 32'h400 + k, 1'b0);
        chk("pre_rst_count", o_count, 5'd7);
        reset = 1'b1;
        #1;
        chk("arst_o_valid", o_valid, 1'b0);
        chk("arst_o_count", o_count, 5'd0);
        chk("arst_o_ready", o_ready, 1'b0);
        chk("arst_o_overflow", o_overflow, 1'b0);
        q.delete(); m_ovf = 1'b0;
        i_valid = 1'b0; i_ready = 1'b0;
        @(negedge clock); reset = 1'b0;
        #1;
        chk("arst_rel_ready0", o_ready, 1'b0);
        @(posedge clock); #1;
        chk("arst_rel_ready1", o_ready, 1'b1);
        m_ready = 1'b1;

        // Wrap-around with random gaps
        begin
            int unsigned n = 0;
            for (int c = 0; c < 2000 && n < 51; c++) begin
                logic v, r;
                v = ($urandom_range(0, 1) == 1) && (q.size() < 16);
                r = ($urandom_range(0, 1) == 1);
                cyc(v, 32'h1000 + n, r);
                if (v) n++;
            end
            chk("wrap_sent", n, 51);
        end
        drain();
        chk("wrap_ovf", o_overflow, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qsys_pipeline_rx_fifo.md
Name: qsys_pipeline_rx_fifo

Overview:
Receive-side buffer that sits directly downstream of a chain of qsys pipeline registers on a latency-insensitive link. Because the upstream valid/data and the returned ready are each delayed by the register chain, the sender keeps issuing words for several cycles after ready drops. This block absorbs those in-flight words in a credit-margined FIFO. It presents a standard valid/ready handshake to the downstream pearl.

Parameters:
DATA_WIDTH, 32, payload width in bits (must be >= 1).
DEPTH, 16, FIFO entries; power of two, >= 4.
SLACK, 5, entries reserved for in-flight words. Set to 2*(pipeline register stages)+1. Legal range 1 <= SLACK <= DEPTH-1.

Ports:
clock  input  1  single clock; all state on posedge.
reset  input  1  asynchronous, active-high reset.
i_data  input  DATA_WIDTH  payload from the upstream pipeline register chain.
i_valid  input  1  payload qualifier from upstream; accepted regardless of o_ready.
o_ready  output  1  credit signal to upstream (travels back through the pipeline registers).
o_data  output  DATA_WIDTH  head-of-FIFO payload to the downstream pearl.
o_valid  output  1  head entry present.
i_ready  input  1  downstream accepts o_data this cycle.
o_count  output  $clog2(DEPTH+1)  current occupancy.
o_overflow  output  1  sticky error: a word arrived while the FIFO was full and could not be stored.

Behaviour:
- Reset is asynchronous and active-high. It takes effect immediately, independent of clock.
- While reset is asserted:
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - o_valid = 0, o_ready = 0, o_overflow = 0, o_count = 0.
  - o_data is don't-care; the bench checks it only when o_valid = 1.
- Storage array is not reset.
- Reset release: o_ready rises on the first posedge after reset deasserts (count = 0 < DEPTH-SLACK). Reset mid-operation discards all contents.
- push = i_valid && (count < DEPTH || pop).
- pop = o_valid && i_ready.
- Push:
  - Write i_data at wr_ptr.
  - wr_ptr increments modulo DEPTH (natural wrap, log2(DEPTH)-bit pointer).
- Pop:
  - rd_ptr increments modulo DEPTH.
- Count update: count += push - pop. Simultaneous push+pop leaves count unchanged, including at full.
- First-word fall-through:
  - o_data = mem[rd_ptr], combinational read of registered storage.
  - o_valid = (count != 0).
  - Latency: a word pushed on edge N is visible on o_valid/o_data after edge N; it can be popped at edge N+1.
- Empty: o_valid = 0. i_ready is ignored and there is no pop. An empty FIFO with a simultaneous push only stores (no bypass).
- o_ready:
  - Registered: o_ready <= (count_next < DEPTH - SLACK).
  - No combinational path from i_valid or i_ready to o_ready.
- Overflow:
  - Condition: i_valid && count == DEPTH && !pop. The word is dropped and o_overflow is set.
  - o_overflow stays set until reset.
  - Normal operation with correct SLACK never sets it.
- o_count = count, a direct register output.
- Ordering is strictly FIFO. No data is duplicated or reordered across pointer wrap.

Test Plan:
- Reset/idle: assert reset mid-stream with count=7 -> o_valid=0, o_count=0 immediately (asynchronous); o_ready=1 one posedge after release; o_overflow=0.
- Passthrough: i_ready=1 constantly, i_valid=1 with data 0x1..0x40 -> o_data sequence identical, each word delayed 1 cycle, o_count never exceeds 1, o_ready stays 1.
- Backpressure margin (DEPTH=16, SLACK=5):
  - Stimulus: i_ready=0, stream words with a modelled ready-to-valid return delay of 2 stages each way.
  - Required: o_ready drops on the cycle after count reaches 11.
  - Required: in-flight words land without loss; final count <= 16, o_overflow=0.
- Full with simultaneous push/pop: fill to 16, then i_valid=1 and i_ready=1 for 10 cycles -> count stays 16, o_overflow=0, output order preserved.
- Overflow: at count=16, i_ready=0, drive i_valid=1 with 0xDEAD -> o_overflow=1 next edge and stays 1. Draining then yields the original 16 words; 0xDEAD never appears.
- Wrap-around: push and pop 3*DEPTH+3 words with random i_valid/i_ready gaps -> scoreboard matches in order; o_count matches the model every cycle.
